// File: rtl/wm8731_pkg.sv
// Shared constants for the WM8731 audio path (capture and playback blocks).
package wm8731_pkg;

  localparam int WM_DATA_W   = 16;
  localparam int FRAME_SLOTS = 2;
  localparam int SYNC_DEPTH  = 3;

endpackage

// File: rtl/edge_sync.sv
// Synchroniser for a codec-driven clock into the system domain, with one-cycle
// rise and fall strobes taken from the last two flops of the chain.
module edge_sync
  import wm8731_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic async_in,
  output logic rise,
  output logic fall
);

  logic [SYNC_DEPTH-1:0] sync_q;
  logic [SYNC_DEPTH-1:0] sync_d;

  always_comb begin
    sync_d = {sync_q[SYNC_DEPTH-2:0], async_in};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign rise = sync_q[SYNC_DEPTH-2] & ~sync_q[SYNC_DEPTH-1];
  assign fall = ~sync_q[SYNC_DEPTH-2] & sync_q[SYNC_DEPTH-1];

endmodule

// File: rtl/sinwave_play.sv
// WM8731 playback serializer: fetches one sample per frame and shifts it out
// MSB-first, left-justified, duplicated on both slots of the frame.
module sinwave_play
  import wm8731_pkg::*;
#(
  parameter int DATA_W = WM_DATA_W,
  parameter int UCNT_W = 8
) (
  input  logic              clock_50M,
  input  logic              reset_n,
  input  logic              bclk,
  input  logic              daclrc,
  input  logic              play_en,
  output logic              wav_rden,
  input  logic [DATA_W-1:0] wav_rd_data,
  input  logic              wav_rd_valid,
  output logic              dacdat,
  output logic              underrun,
  output logic [UCNT_W-1:0] underrun_cnt
);

  localparam int FRAME_W = FRAME_SLOTS * DATA_W;
  localparam int BCNT_W  = $clog2(FRAME_W + 1);
  localparam logic [BCNT_W-1:0] BCNT_MAX = BCNT_W'(FRAME_W);

  logic lrc_rise, lrc_fall_unused;
  logic bclk_fall, bclk_rise_unused;

  edge_sync u_lrc_sync (
    .clk      (clock_50M),
    .rst_n    (reset_n),
    .async_in (daclrc),
    .rise     (lrc_rise),
    .fall     (lrc_fall_unused)
  );

  edge_sync u_bclk_sync (
    .clk      (clock_50M),
    .rst_n    (reset_n),
    .async_in (bclk),
    .rise     (bclk_rise_unused),
    .fall     (bclk_fall)
  );

  logic [DATA_W-1:0]  buf_q, buf_d;
  logic               buf_full_q, buf_full_d;
  logic               pend_q, pend_d;
  logic [FRAME_W-1:0] shreg_q, shreg_d;
  logic [BCNT_W-1:0]  bitcnt_q, bitcnt_d;
  logic               dacdat_q, dacdat_d;
  logic               wav_rden_q, wav_rden_d;
  logic               underrun_q, underrun_d;
  logic [UCNT_W-1:0]  ucnt_q, ucnt_d;
  logic [DATA_W-1:0]  sample;

  always_comb begin
    buf_d      = buf_q;
    buf_full_d = buf_full_q;
    pend_d     = pend_q;
    shreg_d    = shreg_q;
    bitcnt_d   = bitcnt_q;
    dacdat_d   = dacdat_q;
    ucnt_d     = ucnt_q;
    wav_rden_d = 1'b0;
    underrun_d = 1'b0;
    sample     = (play_en && buf_full_q) ? buf_q : '0;

    // A frame start always leaves the buffer empty: it is either consumed or flushed.
    if (lrc_rise) begin
      dacdat_d   = sample[DATA_W-1];
      shreg_d    = {sample, sample} << 1;
      bitcnt_d   = BCNT_W'(1);
      buf_full_d = 1'b0;
      if (play_en && pend_q) begin
        underrun_d = 1'b1;
        if (ucnt_q != '1) begin
          ucnt_d = ucnt_q + 1'b1;
        end
      end
    end else if (bclk_fall) begin
      if (bitcnt_q < BCNT_MAX) begin
        dacdat_d = shreg_q[FRAME_W-1];
        shreg_d  = shreg_q << 1;
        bitcnt_d = bitcnt_q + 1'b1;
      end else begin
        dacdat_d = 1'b0;
      end
    end

    // Late data is still accepted after an underrun; it plays in the next frame.
    if (wav_rd_valid && pend_q) begin
      pend_d = 1'b0;
      if (play_en) begin
        buf_d      = wav_rd_data;
        buf_full_d = 1'b1;
      end
    end

    if (lrc_rise && play_en && !pend_q && !buf_full_d) begin
      wav_rden_d = 1'b1;
      pend_d     = 1'b1;
    end
  end

  always_ff @(posedge clock_50M or negedge reset_n) begin
    if (!reset_n) begin
      buf_q      <= '0;
      buf_full_q <= 1'b0;
      pend_q     <= 1'b0;
      shreg_q    <= '0;
      bitcnt_q   <= '0;
      dacdat_q   <= 1'b0;
      wav_rden_q <= 1'b0;
      underrun_q <= 1'b0;
      ucnt_q     <= '0;
    end else begin
      buf_q      <= buf_d;
      buf_full_q <= buf_full_d;
      pend_q     <= pend_d;
      shreg_q    <= shreg_d;
      bitcnt_q   <= bitcnt_d;
      dacdat_q   <= dacdat_d;
      wav_rden_q <= wav_rden_d;
      underrun_q <= underrun_d;
      ucnt_q     <= ucnt_d;
    end
  end

  assign dacdat       = dacdat_q;
  assign wav_rden     = wav_rden_q;
  assign underrun     = underrun_q;
  assign underrun_cnt = ucnt_q;

endmodule

// File: tb/tb_sinwave_play.sv
// Bench for sinwave_play: directed frames drive bclk/daclrc, expected serial bits
// and per-frame pulse counts go into queues checked by independent monitors.
`timescale 1ns/1ps
module tb_sinwave_play;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        bclk = 1'b1;
  logic        daclrc = 1'b0;
  logic        play_en = 1'b0;
  logic        play_en2 = 1'b1;
  logic        resp_en = 1'b1;
  logic        resp_valid = 1'b0;
  logic [15:0] resp_data = 16'h0;
  logic        man_valid = 1'b0;
  logic [15:0] man_data = 16'h0;
  logic        wav_rd_valid;
  logic [15:0] wav_rd_data;
  logic        wav_rden, dacdat, underrun;
  logic [7:0]  underrun_cnt;
  logic        wav_rden2_unused, dacdat2_unused, underrun2_unused;
  logic [1:0]  underrun_cnt2;

  int checks = 0;
  int errors = 0;
  int rden_seen = 0;
  int und_seen = 0;

  assign wav_rd_valid = resp_valid | man_valid;
  assign wav_rd_data  = man_valid ? man_data : resp_data;

  always #10 clk = ~clk;

  sinwave_play #(.DATA_W(16), .UCNT_W(8)) dut (
    .clock_50M    (clk),
    .reset_n      (reset_n),
    .bclk         (bclk),
    .daclrc       (daclrc),
    .play_en      (play_en),
    .wav_rden     (wav_rden),
    .wav_rd_data  (wav_rd_data),
    .wav_rd_valid (wav_rd_valid),
    .dacdat       (dacdat),
    .underrun     (underrun),
    .underrun_cnt (underrun_cnt)
  );

  // Starved instance with a 2-bit counter: every frame after priming underruns.
  sinwave_play #(.DATA_W(16), .UCNT_W(2)) dut_sat (
    .clock_50M    (clk),
    .reset_n      (reset_n),
    .bclk         (bclk),
    .daclrc       (daclrc),
    .play_en      (play_en2),
    .wav_rden     (wav_rden2_unused),
    .wav_rd_data  (16'h0),
    .wav_rd_valid (1'b0),
    .dacdat       (dacdat2_unused),
    .underrun     (underrun2_unused),
    .underrun_cnt (underrun_cnt2)
  );

  typedef struct {
    logic v;
    int   f;
    int   i;
  } bexp_t;

  typedef struct {
    int f;
    int rden;
    int und;
    int ucnt;
    int ucnt2;
  } fexp_t;

  bexp_t exp_bit_q[$];
  fexp_t exp_frame_q[$];
  event  frame_done;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, expv);
    end
  endtask

  always @(negedge clk) begin
    if (wav_rden === 1'b1) rden_seen <= rden_seen + 1;
    if (underrun === 1'b1) und_seen <= und_seen + 1;
  end

  // Memory model: answers each request with 0xA5C3 ten cycles later when enabled.
  initial begin : responder
    forever begin
      @(negedge clk);
      if (wav_rden === 1'b1 && resp_en) begin
        repeat (10) @(posedge clk);
        #1;
        resp_data  = 16'hA5C3;
        resp_valid = 1'b1;
        @(posedge clk);
        #1;
        resp_valid = 1'b0;
      end
    end
  end

  // The codec samples dacdat on rising bclk.
  initial begin : bit_monitor
    bexp_t e;
    forever begin
      @(posedge bclk);
      if (exp_bit_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL dacdat: bclk rise with no expected bit, got %0b", dacdat);
      end else begin
        e = exp_bit_q.pop_front();
        check($sformatf("dacdat f%0d b%0d", e.f, e.i), {63'd0, dacdat}, {63'd0, e.v});
      end
    end
  end

  initial begin : frame_monitor
    fexp_t e;
    int rden_base;
    int und_base;
    rden_base = 0;
    und_base  = 0;
    forever begin
      @(frame_done);
      e = exp_frame_q.pop_front();
      check($sformatf("f%0d wav_rden count", e.f), 64'(rden_seen - rden_base), 64'(e.rden));
      check($sformatf("f%0d underrun count", e.f), 64'(und_seen - und_base), 64'(e.und));
      check($sformatf("f%0d underrun_cnt", e.f), {56'd0, underrun_cnt}, 64'(e.ucnt));
      check($sformatf("f%0d underrun_cnt sat", e.f), {62'd0, underrun_cnt2}, 64'(e.ucnt2));
      $display("frame %0d: rden %0d underrun %0d cnt %0d sat_cnt %0d", e.f,
               rden_seen - rden_base, und_seen - und_base, underrun_cnt, underrun_cnt2);
      rden_base = rden_seen;
      und_base  = und_seen;
    end
  end

  task automatic check_outputs_zero(input string tag);
    check({tag, " dacdat"}, {63'd0, dacdat}, 64'd0);
    check({tag, " wav_rden"}, {63'd0, wav_rden}, 64'd0);
    check({tag, " underrun"}, {63'd0, underrun}, 64'd0);
    check({tag, " underrun_cnt"}, {56'd0, underrun_cnt}, 64'd0);
    check({tag, " underrun_cnt sat"}, {62'd0, underrun_cnt2}, 64'd0);
  endtask

  task automatic man_pulse(input logic [15:0] d, input int pre);
    repeat (pre) @(posedge clk);
    #1;
    man_data  = d;
    man_valid = 1'b1;
    @(posedge clk);
    #1;
    man_valid = 1'b0;
  endtask

  // One codec frame of nb bclk periods; LRC rises on the first bclk fall.
  task automatic run_frame(input int f, input int nb, input logic [15:0] samp,
                           input int rden, input int und, input int ucnt, input int ucnt2,
                           input int inj_bit, input int inj_pre, input logic [15:0] inj_data,
                           input int pe_off_at, input int rst_at, input int rst_rel);
    logic [31:0] word;
    time         t0;
    fexp_t       fe;
    bexp_t       be;
    word     = {samp, samp};
    fe.f     = f;
    fe.rden  = rden;
    fe.und   = und;
    fe.ucnt  = ucnt;
    fe.ucnt2 = ucnt2;
    exp_frame_q.push_back(fe);
    for (int i = 0; i < nb; i++) begin
      t0   = $time;
      bclk = 1'b0;
      if (i == 0) daclrc = 1'b1;
      if (i == nb / 2) daclrc = 1'b0;
      if (i == inj_bit) man_pulse(inj_data, inj_pre);
      if (i == pe_off_at) play_en = 1'b0;
      if (i == rst_at) begin
        #20;
        reset_n = 1'b0;
        #1;
        check_outputs_zero($sformatf("f%0d reset", f));
      end
      if (i == rst_rel) begin
        #20;
        reset_n = 1'b1;
      end
      #(160 - ($time - t0));
      be.f = f;
      be.i = i;
      if (rst_at >= 0 && i >= rst_at) be.v = 1'b0;
      else if (i < 32)                be.v = word[31-i];
      else                            be.v = 1'b0;
      exp_bit_q.push_back(be);
      bclk = 1'b1;
      #160;
    end
    -> frame_done;
  endtask

  initial begin : stimulus
    #45;
    check_outputs_zero("in reset");
    #60;
    reset_n = 1'b1;
    #200;
    play_en = 1'b1;
    #200;
    check_outputs_zero("idle after reset");

    //        f  nb  sample    rden und ucnt sat inj  pre data      peoff rst rel
    run_frame(0, 64, 16'h0000, 1,   0,  0,   0,  -1,  0,  16'h0000, -1,   -1, -1);
    resp_en = 1'b0;
    run_frame(1, 64, 16'hA5C3, 1,   0,  0,   1,  -1,  0,  16'h0000, -1,   -1, -1);
    run_frame(2, 64, 16'h0000, 0,   1,  1,   2,  5,   1,  16'h1234, -1,   -1, -1);
    run_frame(3, 64, 16'h1234, 1,   0,  1,   3,  -1,  0,  16'h0000, -1,   -1, -1);
    run_frame(4, 64, 16'h0000, 0,   1,  2,   3,  0,   2,  16'h7FFF, -1,   -1, -1);
    resp_en = 1'b1;
    run_frame(5, 64, 16'h7FFF, 1,   0,  2,   3,  -1,  0,  16'h0000, 40,   -1, -1);
    run_frame(6, 64, 16'h0000, 0,   0,  2,   3,  5,   1,  16'h4321, -1,   -1, -1);
    play_en = 1'b1;
    run_frame(7, 64, 16'h0000, 1,   0,  2,   3,  -1,  0,  16'h0000, -1,   -1, -1);
    run_frame(8, 40, 16'hA5C3, 1,   0,  2,   3,  -1,  0,  16'h0000, -1,   -1, -1);
    run_frame(9, 24, 16'hA5C3, 1,   0,  2,   3,  -1,  0,  16'h0000, -1,   -1, -1);
    run_frame(10, 64, 16'hA5C3, 1,  0,  2,   3,  -1,  0,  16'h0000, -1,   -1, -1);
    run_frame(11, 64, 16'hA5C3, 1,  0,  0,   0,  -1,  0,  16'h0000, -1,   10, 40);
    run_frame(12, 64, 16'h0000, 1,  0,  0,   0,  -1,  0,  16'h0000, -1,   -1, -1);
    run_frame(13, 64, 16'hA5C3, 1,  0,  0,   1,  -1,  0,  16'h0000, -1,   -1, -1);

    #100;
    check("expected bits drained", 64'(exp_bit_q.size()), 64'd0);
    check("expected frames drained", 64'(exp_frame_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
